// File: rtl/alu_mul_seq.sv
// ============================================================================
// alu_mul_seq : shift-and-add multiplier that borrows the shared alu adder
// Revision    : 1.0
// ============================================================================
`default_nettype none

`ifndef ADD_OP
`define ADD_OP 6'h20
`endif

module alu_mul_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic [WIDTH-1:0] opr_a_i,
  input  logic [WIDTH-1:0] opr_b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] res_o,
  output logic             alu_req_o,
  input  logic             alu_gnt_i,
  output logic [WIDTH-1:0] alu_opr_a_o,
  output logic [WIDTH-1:0] alu_opr_b_o,
  output logic [5:0]       alu_op_o,
  input  logic [WIDTH-1:0] alu_res_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] acc, acc_nxt;
  logic [WIDTH-1:0] mcand, mcand_nxt;
  logic [WIDTH-1:0] mplier, mplier_nxt;
  logic [WIDTH-1:0] res, res_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      res    <= '0;
    end else begin
      state  <= state_nxt;
      acc    <= acc_nxt;
      mcand  <= mcand_nxt;
      mplier <= mplier_nxt;
      res    <= res_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    acc_nxt     = acc;
    mcand_nxt   = mcand;
    mplier_nxt  = mplier;
    res_nxt     = res;
    alu_req_o   = 1'b0;
    alu_opr_a_o = '0;
    alu_opr_b_o = '0;
    alu_op_o    = `ADD_OP;

    case (state)
      IDLE: begin
        if (start_i) begin
          acc_nxt    = '0;
          mcand_nxt  = opr_a_i;
          mplier_nxt = opr_b_i;
          state_nxt  = RUN;
        end
      end

      RUN: begin
        if (mplier == '0) begin
          res_nxt   = acc;
          state_nxt = DONE;
        end else if (!mplier[0]) begin
          mcand_nxt  = mcand << 1;
          mplier_nxt = mplier >> 1;
        end else begin
          // Without a grant everything holds, so the request repeats unchanged.
          alu_req_o   = 1'b1;
          alu_opr_a_o = acc;
          alu_opr_b_o = mcand;
          if (alu_gnt_i) begin
            acc_nxt    = alu_res_i;
            mcand_nxt  = mcand << 1;
            mplier_nxt = mplier >> 1;
          end
        end
      end

      DONE: begin
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign busy_o = (state != IDLE);
  assign done_o = (state == DONE);
  assign res_o  = res;

endmodule

`default_nettype wire

// File: tb/tb_alu_mul_seq.sv
// ============================================================================
// tb_alu_mul_seq : table, hand-written and random checks of alu_mul_seq
// Revision       : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

`ifndef ADD_OP
`define ADD_OP 6'h20
`endif

module tb_alu_mul_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_i;
  logic [31:0] opr_a_i;
  logic [31:0] opr_b_i;
  logic        busy_o;
  logic        done_o;
  logic [31:0] res_o;
  logic        alu_req_o;
  logic        alu_gnt_i;
  logic [31:0] alu_opr_a_o;
  logic [31:0] alu_opr_b_o;
  logic [5:0]  alu_op_o;
  logic [31:0] alu_res_i;

  alu_mul_seq #(.WIDTH(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .start_i     (start_i),
    .opr_a_i     (opr_a_i),
    .opr_b_i     (opr_b_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .res_o       (res_o),
    .alu_req_o   (alu_req_o),
    .alu_gnt_i   (alu_gnt_i),
    .alu_opr_a_o (alu_opr_a_o),
    .alu_opr_b_o (alu_opr_b_o),
    .alu_op_o    (alu_op_o),
    .alu_res_i   (alu_res_i)
  );

  always #5 clk = ~clk;

  // The shared alu: a plain adder when asked to add.
  assign alu_res_i = (alu_op_o == `ADD_OP) ? (alu_opr_a_o + alu_opr_b_o) : 32'h0;

  int total = 0;
  int bad   = 0;
  int gnt_mode;    // 0: always granted, 1: random, 2: withhold for stall_left req cycles
  int stall_left;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_res;
    int          exp_done;
    int          exp_grants;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic int top_bits(input logic [31:0] b);
    int k = 0;
    for (int i = 0; i < 32; i++) if (b[i]) k = i + 1;
    return k;
  endfunction

  // Start one operation at cycle 0 and follow it until done_o.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input bit inject,
                        output logic [31:0] res, output int done_cyc, output int grants,
                        output int stalls, output logic [31:0] req_mask);
    bit          prev_stall = 0;
    bit          finished   = 0;
    logic [31:0] pa = '0;
    logic [31:0] pb = '0;
    grants   = 0;
    stalls   = 0;
    req_mask = '0;
    done_cyc = -1;
    res      = '0;
    @(posedge clk); #1;
    start_i = 1'b1; opr_a_i = a; opr_b_i = b; alu_gnt_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0; opr_a_i = '0; opr_b_i = '0;
    for (int cyc = 1; cyc < 200; cyc++) begin
      case (gnt_mode)
        0:       alu_gnt_i = 1'b1;
        1:       alu_gnt_i = 1'($urandom_range(0, 1));
        default: alu_gnt_i = (stall_left == 0);
      endcase
      if (inject && cyc == 2) begin
        start_i = 1'b1; opr_a_i = 32'd9; opr_b_i = 32'd9;
      end else begin
        start_i = 1'b0;
      end
      #1;
      if (prev_stall) begin
        chk("hold_req", {31'b0, alu_req_o}, 32'd1);
        chk("hold_opr_a", alu_opr_a_o, pa);
        chk("hold_opr_b", alu_opr_b_o, pb);
      end
      prev_stall = 0;
      if (alu_op_o !== `ADD_OP) chk("alu_op", {26'b0, alu_op_o}, {26'b0, `ADD_OP});
      if (!alu_req_o && (alu_opr_a_o | alu_opr_b_o) !== 32'h0)
        chk("idle_opr", alu_opr_a_o | alu_opr_b_o, 32'h0);
      if (done_o) begin
        done_cyc = cyc;
        res      = res_o;
        finished = 1;
        break;
      end
      if (!busy_o) chk("busy_in_run", {31'b0, busy_o}, 32'd1);
      if (alu_req_o) begin
        if (cyc < 32) req_mask[cyc] = 1'b1;
        if (alu_gnt_i) begin
          grants++;
        end else begin
          stalls++;
          prev_stall = 1;
          pa = alu_opr_a_o;
          pb = alu_opr_b_o;
          if (stall_left > 0) stall_left--;
        end
      end
      @(posedge clk); #1;
    end
    if (!finished) chk("timeout", 32'd0, 32'd1);
    start_i = inject;
    opr_a_i = inject ? 32'd9 : 32'd0;
    opr_b_i = inject ? 32'd9 : 32'd0;
    @(posedge clk); #1;
    start_i = 1'b0; opr_a_i = '0; opr_b_i = '0;
    #1;
    chk("done_one_cycle", {31'b0, done_o}, 32'd0);
    chk("idle_after_done", {31'b0, busy_o}, 32'd0);
  endtask

  logic [31:0] r, mask, ra, rb;
  int          dc, gr, st;

  initial begin
    reset = 1'b1; start_i = 1'b0; opr_a_i = '0; opr_b_i = '0; alu_gnt_i = 1'b1;
    gnt_mode = 0; stall_left = 0;

    vecs[0] = '{32'd3,         32'd5,         32'd15,        5,  2};
    vecs[1] = '{32'h1234,      32'd0,         32'd0,         2,  0};
    vecs[2] = '{32'hFFFFFFFF,  32'hFFFFFFFF,  32'h1,         34, 32};
    vecs[3] = '{32'h80000000,  32'd2,         32'd0,         4,  1};
    vecs[4] = '{32'd6,         32'd7,         32'd42,        5,  3};
    vecs[5] = '{32'hDEADBEEF,  32'd1,         32'hDEADBEEF,  3,  1};

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    chk("rst_busy", {31'b0, busy_o}, 32'd0);
    chk("rst_done", {31'b0, done_o}, 32'd0);
    chk("rst_res", res_o, 32'd0);
    chk("rst_req", {31'b0, alu_req_o}, 32'd0);

    for (int i = 0; i < 6; i++) begin
      run_op(vecs[i].a, vecs[i].b, 0, r, dc, gr, st, mask);
      chk($sformatf("vec%0d_res", i), r, vecs[i].exp_res);
      chk($sformatf("vec%0d_done_cyc", i), dc, vecs[i].exp_done);
      chk($sformatf("vec%0d_grants", i), gr, vecs[i].exp_grants);
      if (i == 0) chk("basic_req_cycles", mask, 32'hA);
      chk($sformatf("vec%0d_res_held", i), res_o, vecs[i].exp_res);
    end

    // Arbitration stall: five withheld grants on the first request.
    gnt_mode = 2; stall_left = 5;
    run_op(32'd7, 32'd3, 0, r, dc, gr, st, mask);
    chk("stall_res", r, 32'd21);
    chk("stall_done_cyc", dc, 32'd9);
    chk("stall_count", st, 32'd5);
    gnt_mode = 0;

    // Starts during RUN and in DONE are ignored.
    run_op(32'd3, 32'd5, 1, r, dc, gr, st, mask);
    chk("busy_start_res", r, 32'd15);
    chk("busy_start_done_cyc", dc, 32'd5);
    @(posedge clk); #2;
    chk("busy_start_idle", {31'b0, busy_o}, 32'd0);
    chk("busy_start_res_held", res_o, 32'd15);

    // Reset in cycle 2 of an operation.
    @(posedge clk); #1;
    start_i = 1'b1; opr_a_i = 32'd3; opr_b_i = 32'd5;
    @(posedge clk); #1;
    start_i = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk("midrst_busy", {31'b0, busy_o}, 32'd0);
    chk("midrst_done", {31'b0, done_o}, 32'd0);
    chk("midrst_res", res_o, 32'd0);
    chk("midrst_req", {31'b0, alu_req_o}, 32'd0);
    run_op(32'd6, 32'd7, 0, r, dc, gr, st, mask);
    chk("after_rst_res", r, 32'd42);
    chk("after_rst_done_cyc", dc, 32'd5);

    // Random operands and random grants against the arithmetic model.
    gnt_mode = 1;
    for (int n = 0; n < 40; n++) begin
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 31);
      run_op(ra, rb, 0, r, dc, gr, st, mask);
      chk($sformatf("rnd%0d_res", n), r, ra * rb);
      chk($sformatf("rnd%0d_done_cyc", n), dc, top_bits(rb) + 2 + st);
      chk($sformatf("rnd%0d_grants", n), gr, $countones(rb));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
